remote_cmd_queue: RTL
=====================

REMOTE_CMD_QUEUE -- requirements
Module: remote_cmd_queue

Interface
REQ-001 SHALL have parameter CMD_BYTES, default 2; bytes per command, range 1..4, sent MSB first.
REQ-002 SHALL have parameter DEPTH, default 4; command FIFO entries, power of 2, range 2..16.
REQ-003 SHALL have parameter TIMEOUT_CLKS, default 10000000; max clocks between responses.
REQ-004 SHALL have port clk, input, 1; single clock, all state on rising edge.
REQ-005 SHALL have port rst, input, 1; asynchronous, active-high reset.
REQ-006 SHALL have port cmd_in, input, 8*CMD_BYTES; command to enqueue.
REQ-007 SHALL have port resp_exp, input, 2; responses expected for cmd_in, 0..3.
REQ-008 SHALL have port push, input, 1; enqueue {cmd_in, resp_exp}.
REQ-009 SHALL have ports full and empty, output, 1 each; FIFO status.
REQ-010 SHALL have port count, output, $clog2(DEPTH+1); queued entries, excluding the one in flight.
REQ-011 SHALL have ports trmt (output, 1), tx_data (output, 8), tx_done (input, 1); byte UART transmit handshake.
REQ-012 SHALL have ports rx_rdy (input, 1), rx_data (input, 8), clr_rx_rdy (output, 1); byte UART receive handshake.
REQ-013 SHALL have ports resp (output, 8), resp_rdy (output, 1), cmd_sent (output, 1), busy (output, 1).
REQ-014 SHALL have ports timeout, overflow (output, 1, sticky) and clr_err (input, 1).

Function
REQ-015 SHALL run FSM states IDLE, SEND, WAIT_TX, WAIT_RESP.
REQ-016 IDLE, FIFO non-empty: SHALL pop head into shift register, byte_idx=0, resp_left=entry resp_exp, go to SEND.
REQ-017 SEND: SHALL assert trmt for exactly one cycle with tx_data = byte CMD_BYTES-1-byte_idx, then go to WAIT_TX.
REQ-018 WAIT_TX on tx_done, byte_idx<CMD_BYTES-1: SHALL increment byte_idx, go to SEND.
REQ-019 WAIT_TX on tx_done, last byte: SHALL pulse cmd_sent one cycle; go to IDLE if resp_left==0, else WAIT_RESP with timer=0.
REQ-020 WAIT_RESP on rx_rdy: SHALL latch rx_data into resp, pulse clr_rx_rdy and resp_rdy one cycle the next cycle, decrement resp_left, clear timer; go to IDLE when resp_left reaches 0.
REQ-021 resp SHALL hold its value until the next response is latched.
REQ-022 WAIT_RESP: timer SHALL count each cycle without rx_rdy; at TIMEOUT_CLKS-1 SHALL set timeout, discard remaining responses, and go to IDLE.
REQ-023 rx_rdy outside WAIT_RESP: SHALL pulse clr_rx_rdy and discard the byte; no resp_rdy, resp unchanged.
REQ-024 Idle, empty FIFO: push at cycle n SHALL give trmt high at cycle n+2.
REQ-025 Push while full SHALL be dropped and set overflow, even if a pop occurs the same cycle.
REQ-026 Push and pop in the same cycle (not full) SHALL leave count unchanged.
REQ-027 FIFO pointers SHALL wrap modulo DEPTH; full when count==DEPTH, empty when count==0.
REQ-028 busy SHALL be high in any state other than IDLE.
REQ-029 clr_err SHALL clear timeout and overflow; a set event in the same cycle SHALL win.
REQ-030 Back-to-back commands SHALL have no idle cycle beyond the IDLE pop cycle.

Reset
REQ-031 rst high SHALL immediately force IDLE, empty FIFO, and zero pointers, count, byte_idx, resp_left and timer.
REQ-032 During reset, all outputs SHALL be 0, except empty=1.
REQ-033 rst mid-command SHALL abandon the in-flight command with no cmd_sent or resp_rdy after release.
REQ-034 The first push is accepted on the first rising edge after rst deasserts.

Verification
REQ-035 Reset, then push 16'h4022 with resp_exp=2 -> trmt with 8'h40, then 8'h22; one cmd_sent; replies A5 then 5A give two resp_rdy pulses, resp=8'h5A at end, busy low.
REQ-036 Push 16'h0000 with resp_exp=0 -> two bytes sent, cmd_sent pulses, IDLE without waiting, timeout stays 0.
REQ-037 Push DEPTH+1 commands while the first is in flight -> count==DEPTH, full=1, overflow=1; the queued DEPTH commands are sent in order; the extra command is never sent.
REQ-038 TIMEOUT_CLKS=100, resp_exp=1, no reply -> timeout set at cycle 100 of WAIT_RESP; the next queued command starts; clr_err clears timeout.
REQ-039 rx_rdy pulse while IDLE -> clr_rx_rdy pulses, no resp_rdy, resp unchanged.
REQ-040 rst asserted between the first and second byte -> outputs 0 immediately; after release empty=1 and no further trmt.

Source files
------------

// File: rtl/remote_cmd_queue.sv
// Command FIFO feeding a byte UART, MSB first, then collecting up to three
// response bytes per command with a watchdog on the gap between responses.
module remote_cmd_queue #(
  parameter int CMD_BYTES    = 2,
  parameter int DEPTH        = 4,
  parameter int TIMEOUT_CLKS = 10000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [8*CMD_BYTES-1:0]       cmd_in,
  input  logic [1:0]                   resp_exp,
  input  logic                         push,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         trmt,
  output logic [7:0]                   tx_data,
  input  logic                         tx_done,
  input  logic                         rx_rdy,
  input  logic [7:0]                   rx_data,
  output logic                         clr_rx_rdy,
  output logic [7:0]                   resp,
  output logic                         resp_rdy,
  output logic                         cmd_sent,
  output logic                         busy,
  output logic                         timeout,
  output logic                         overflow,
  input  logic                         clr_err
);

  localparam int CW = 8 * CMD_BYTES;
  localparam int AW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH + 1);
  localparam int BW = (CMD_BYTES > 1) ? $clog2(CMD_BYTES) : 1;
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [BW-1:0] LAST = BW'(CMD_BYTES - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_TX,
    WAIT_RESP
  } state_t;

  state_t          state_q, state_d;
  logic [CW+1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [NW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   sh_q, sh_d;
  logic [BW-1:0]   bidx_q, bidx_d;
  logic [1:0]      left_q, left_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [7:0]      resp_q, resp_d;
  logic            sent_q, sent_d;
  logic            rdy_q, rdy_d;
  logic            clr_q, clr_d;
  logic            to_q, to_d;
  logic            ov_q, ov_d;
  logic            pop, push_ok, to_set, ov_set;

  assign full    = (cnt_q == NW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push && !full;
  assign ov_set  = push && full;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= {cmd_in, resp_exp};
  end

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) wr_d = wr_q + AW'(1);
    if (pop)     rd_d = rd_q + AW'(1);
    unique case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + NW'(1);
      2'b01:   cnt_d = cnt_q - NW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bidx_d  = bidx_q;
    left_d  = left_q;
    timer_d = timer_q;
    resp_d  = resp_q;
    pop     = 1'b0;
    sent_d  = 1'b0;
    rdy_d   = 1'b0;
    to_set  = 1'b0;
    clr_d   = rx_rdy;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop            = 1'b1;
          {sh_d, left_d} = mem_q[rd_q];
          bidx_d         = '0;
          state_d        = SEND;
        end
      end
      SEND: state_d = WAIT_TX;
      WAIT_TX: begin
        if (tx_done) begin
          if (bidx_q != LAST) begin
            bidx_d  = bidx_q + BW'(1);
            sh_d    = sh_q << 8;
            state_d = SEND;
          end else begin
            sent_d  = 1'b1;
            timer_d = '0;
            state_d = (left_q == 2'd0) ? IDLE : WAIT_RESP;
          end
        end
      end
      WAIT_RESP: begin
        if (rx_rdy) begin
          resp_d  = rx_data;
          rdy_d   = 1'b1;
          left_d  = left_q - 2'd1;
          timer_d = '0;
          if (left_q == 2'd1) state_d = IDLE;
        end else if (timer_q == TMAX) begin
          // unanswered responses are abandoned so the queue keeps moving
          to_set  = 1'b1;
          left_d  = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
    endcase
  end

  always_comb begin
    to_d = to_q;
    ov_d = ov_q;
    if (clr_err) begin
      to_d = 1'b0;
      ov_d = 1'b0;
    end
    if (to_set) to_d = 1'b1;
    if (ov_set) ov_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
      bidx_q  <= '0;
      left_q  <= '0;
      timer_q <= '0;
      resp_q  <= '0;
      sent_q  <= 1'b0;
      rdy_q   <= 1'b0;
      clr_q   <= 1'b0;
      to_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      bidx_q  <= bidx_d;
      left_q  <= left_d;
      timer_q <= timer_d;
      resp_q  <= resp_d;
      sent_q  <= sent_d;
      rdy_q   <= rdy_d;
      clr_q   <= clr_d;
      to_q    <= to_d;
      ov_q    <= ov_d;
    end
  end

  assign count      = cnt_q;
  assign trmt       = (state_q == SEND);
  assign tx_data    = trmt ? sh_q[CW-1 -: 8] : 8'h00;
  assign busy       = (state_q != IDLE);
  assign resp       = resp_q;
  assign resp_rdy   = rdy_q;
  assign cmd_sent   = sent_q;
  assign clr_rx_rdy = clr_q;
  assign timeout    = to_q;
  assign overflow   = ov_q;

endmodule
